game_phase_sequencer: RTL

//  Top-level game-phase controller for the lane game. Sequences screen clear, start

---
 rtl/game_phase_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/game_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_phase_sequencer
// Purpose  : Lane-game phase controller. It steps through screen clear,
//            start countdown, play, crash freeze and game-over. It gates
//            the datapath with run_enable and tracks the survival score
//            and the difficulty level.
// Revision : 1.0 - initial release
// ============================================================================
module game_phase_sequencer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int LEVEL_UP_SEC  = 10,
    parameter int MAX_LEVEL     = 7,
    parameter int FREEZE_SEC    = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    input  logic        collision,
    input  logic        clear_done,
    output logic        clear_req,
    output logic        run_enable,
    output logic        game_over,
    output logic [3:0]  countdown_val,
    output logic        sec_tick,
    output logic [2:0]  level,
    output logic [15:0] score
);

    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int LVL_W  = (LEVEL_UP_SEC > 1)  ? $clog2(LEVEL_UP_SEC)  : 1;
    localparam int FRZ_W  = (FREEZE_SEC > 1)    ? $clog2(FREEZE_SEC)    : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [LVL_W-1:0]  LVL_LAST   = LVL_W'(LEVEL_UP_SEC - 1);
    localparam logic [LVL_W-1:0]  LVL_ONE    = LVL_W'(1);
    localparam logic [FRZ_W-1:0]  FRZ_LAST   = FRZ_W'(FREEZE_SEC - 1);
    localparam logic [FRZ_W-1:0]  FRZ_ONE    = FRZ_W'(1);
    localparam logic [3:0]        COUNT_INIT = 4'(COUNTDOWN_SEC);
    localparam logic [2:0]        LEVEL_MAX  = 3'(MAX_LEVEL);

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_COUNT  = 3'd2,
        ST_PLAY   = 3'd3,
        ST_FREEZE = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              auto_start;
    logic              auto_start_nx;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_nx;
    logic [LVL_W-1:0]  lvl_cnt;
    logic [LVL_W-1:0]  lvl_cnt_nx;
    logic [FRZ_W-1:0]  frz_cnt;
    logic [FRZ_W-1:0]  frz_cnt_nx;
    logic              clear_req_nx;
    logic              run_enable_nx;
    logic              game_over_nx;
    logic [3:0]        countdown_nx;
    logic              sec_tick_nx;
    logic [2:0]        level_nx;
    logic [15:0]       score_nx;
    logic              counting_now;
    logic              counting_nx;

    // Phase register; reset always lands in the clear phase.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    // Next phase, counters and registered output values. sec_tick is computed
    // one cycle ahead so the registered pulse sits on the wrap cycle itself,
    // which lets it double as the internal second event.
    always_comb begin
        state_nx      = state;
        auto_start_nx = auto_start;
        countdown_nx  = countdown_val;
        score_nx      = score;
        level_nx      = level;
        lvl_cnt_nx    = lvl_cnt;
        frz_cnt_nx    = frz_cnt;
        tick_cnt_nx   = '0;

        case (state)
            ST_CLEAR: begin
                if (clear_done) begin
                    state_nx = auto_start ? ST_COUNT : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sec_tick) begin
                    if (countdown_val <= 4'd1) begin
                        state_nx     = ST_PLAY;
                        countdown_nx = 4'd0;
                    end else begin
                        countdown_nx = countdown_val - 4'd1;
                    end
                end
            end
            ST_PLAY: begin
                // A crash wins over a coinciding second: nothing is scored.
                if (collision) begin
                    state_nx = ST_FREEZE;
                end else if (sec_tick) begin
                    if (score != 16'hFFFF) begin
                        score_nx = score + 16'd1;
                    end
                    if (lvl_cnt == LVL_LAST) begin
                        lvl_cnt_nx = '0;
                        if (level < LEVEL_MAX) begin
                            level_nx = level + 3'd1;
                        end
                    end else begin
                        lvl_cnt_nx = lvl_cnt + LVL_ONE;
                    end
                end
            end
            ST_FREEZE: begin
                if (sec_tick) begin
                    if (frz_cnt == FRZ_LAST) begin
                        state_nx = ST_OVER;
                    end else begin
                        frz_cnt_nx = frz_cnt + FRZ_ONE;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_nx      = ST_CLEAR;
                    auto_start_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_CLEAR;
            end
        endcase

        // Entry actions for a new round and for the freeze timer.
        if ((state_nx == ST_COUNT) && (state != ST_COUNT)) begin
            countdown_nx  = COUNT_INIT;
            score_nx      = 16'd0;
            level_nx      = 3'd0;
            lvl_cnt_nx    = '0;
            auto_start_nx = 1'b0;
        end
        if ((state_nx == ST_FREEZE) && (state != ST_FREEZE)) begin
            frz_cnt_nx = '0;
        end

        counting_now = (state == ST_COUNT) || (state == ST_PLAY) || (state == ST_FREEZE);
        counting_nx  = (state_nx == ST_COUNT) || (state_nx == ST_PLAY) ||
                       (state_nx == ST_FREEZE);

        // Tick counter restarts from zero on every phase entry.
        if ((state_nx == state) && counting_now) begin
            tick_cnt_nx = sec_tick ? '0 : (tick_cnt + TICK_ONE);
        end

        sec_tick_nx   = counting_nx && (tick_cnt_nx == TICK_LAST);
        clear_req_nx  = (state_nx == ST_CLEAR);
        run_enable_nx = (state_nx == ST_PLAY);
        game_over_nx  = (state_nx == ST_FREEZE) || (state_nx == ST_OVER);
    end

    // Counters, flags and registered outputs.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            auto_start    <= 1'b0;
            tick_cnt      <= '0;
            lvl_cnt       <= '0;
            frz_cnt       <= '0;
            clear_req     <= 1'b1;
            run_enable    <= 1'b0;
            game_over     <= 1'b0;
            countdown_val <= 4'd0;
            sec_tick      <= 1'b0;
            level         <= 3'd0;
            score         <= 16'd0;
        end else begin
            auto_start    <= auto_start_nx;
            tick_cnt      <= tick_cnt_nx;
            lvl_cnt       <= lvl_cnt_nx;
            frz_cnt       <= frz_cnt_nx;
            clear_req     <= clear_req_nx;
            run_enable    <= run_enable_nx;
            game_over     <= game_over_nx;
            countdown_val <= countdown_nx;
            sec_tick      <= sec_tick_nx;
            level         <= level_nx;
            score         <= score_nx;
        end
    end

endmodule
`default_nettype wire
